// File: rtl/pe_pkg.sv
// Shared types and widths for the PE shift-and-add accumulator.
package pe_pkg;

    localparam int nAdderOutBits  = 6;
    localparam int inputPrecision = 4;
    localparam int accWidth       = nAdderOutBits + inputPrecision;
    localparam int cntWidth       = $clog2(inputPrecision);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    typedef logic [accWidth-1:0] acc_word_t;
    typedef logic [cntWidth-1:0] plane_cnt_t;

    localparam plane_cnt_t LAST_PLANE = plane_cnt_t'(inputPrecision - 1);

endpackage

// File: rtl/pe_shift_accumulator_if.sv
// Plane input / result handshake bundle between the PE, the accumulator and the output stage.
interface pe_shift_accumulator_if #(
    parameter int nSaCols = 256
) ();
    import pe_pkg::*;

    logic                                       start_i;
    logic                                       plane_valid_i;
    logic [nSaCols-1:0][nAdderOutBits-1:0]      plane_i;
    acc_word_t [nSaCols-1:0]                    acc_o;
    logic                                       acc_valid_o;
    logic                                       acc_ready_i;
    logic                                       busy_o;
    logic                                       overrun_o;

    modport master (
        output start_i, plane_valid_i, plane_i, acc_ready_i,
        input  acc_o, acc_valid_o, busy_o, overrun_o
    );

    modport slave (
        input  start_i, plane_valid_i, plane_i, acc_ready_i,
        output acc_o, acc_valid_o, busy_o, overrun_o
    );

endinterface

// File: rtl/pe_acc_lane.sv
// One column of the shift-and-add accumulator: running sum plus the registered result.
module pe_acc_lane
    import pe_pkg::*;
(
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [nAdderOutBits-1:0] plane,
    input  plane_cnt_t               shift,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     sub,
    input  logic                     load,
    output acc_word_t                result
);

    acc_word_t acc;
    acc_word_t base;
    acc_word_t shifted;
    acc_word_t sum;

    // clr and en together start a new vector whose plane 0 is already present
    always_comb begin
        base    = clr ? '0 : acc;
        shifted = acc_word_t'(plane) << shift;
        sum     = sub ? (base - shifted) : (base + shifted);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (en) begin
                acc <= sum;
            end else if (clr) begin
                acc <= '0;
            end
            if (load) begin
                result <= sum;
            end
        end
    end

endmodule

// File: rtl/pe_shift_accumulator.sv
// Bit-serial shift-and-add stage behind the PE; weights each bit-plane by 2^bit and holds the dot products.
// Define SIGNED_MSB_EN to treat inputs as two's complement (MSB plane subtracted).
//
// state | meaning
// IDLE  | waiting for start_i; plane_valid_i ignored
// ACCUM | accumulating planes LSB first; start_i aborts and restarts
// HOLD  | acc_o valid, waiting for acc_ready_i; new starts dropped unless ready
module pe_shift_accumulator
    import pe_pkg::*;
#(
    parameter int nSaCols = 256
) (
    input  logic                    clk,
    input  logic                    nrst,
    pe_shift_accumulator_if.slave   bus
);

    state_t     state;
    state_t     state_nxt;
    plane_cnt_t cnt;
    plane_cnt_t cnt_nxt;
    plane_cnt_t shift_amt;
    logic       clr;
    logic       en;
    logic       load;
    logic       sub;
    logic       overrun_nxt;
    logic       overrun_q;

    acc_word_t [nSaCols-1:0] acc_res;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            overrun_q <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        clr         = 1'b0;
        en          = 1'b0;
        load        = 1'b0;
        overrun_nxt = 1'b0;
        shift_amt   = cnt;

        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    clr       = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.start_i) begin
                    overrun_nxt = 1'b1;
                    clr         = 1'b1;
                    en          = bus.plane_valid_i;
                    shift_amt   = '0;
                    cnt_nxt     = bus.plane_valid_i ? plane_cnt_t'(1) : '0;
                end else if (bus.plane_valid_i) begin
                    en = 1'b1;
                    if (cnt == LAST_PLANE) begin
                        load      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt + plane_cnt_t'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.acc_ready_i) begin
                    if (bus.start_i) begin
                        clr       = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (bus.start_i) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef SIGNED_MSB_EN
        sub = en && (shift_amt == LAST_PLANE);
`else
        sub = 1'b0;
`endif
    end

    for (genvar c = 0; c < nSaCols; c++) begin : g_lane
        pe_acc_lane u_lane (
            .clk    (clk),
            .nrst   (nrst),
            .plane  (bus.plane_i[c]),
            .shift  (shift_amt),
            .clr    (clr),
            .en     (en),
            .sub    (sub),
            .load   (load),
            .result (acc_res[c])
        );
    end

    assign bus.acc_o       = acc_res;
    assign bus.acc_valid_o = (state == HOLD);
    assign bus.busy_o      = (state == ACCUM);
    assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_pe_shift_accumulator.sv
// Scoreboard bench for pe_shift_accumulator with 4 columns; honours SIGNED_MSB_EN like the design.
module tb_pe_shift_accumulator;
    import pe_pkg::*;

    localparam int NC = 4;

    typedef logic [NC-1:0][nAdderOutBits-1:0] pl_t;
    typedef logic [NC-1:0][accWidth-1:0]      res_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    res_t sb[$];

    pe_shift_accumulator_if #(.nSaCols(NC)) bus ();

    pe_shift_accumulator #(.nSaCols(NC)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pl_t mk(input int a0, input int a1, input int a2, input int a3);
        pl_t r;
        r[0] = nAdderOutBits'(a0);
        r[1] = nAdderOutBits'(a1);
        r[2] = nAdderOutBits'(a2);
        r[3] = nAdderOutBits'(a3);
        return r;
    endfunction

    // Reference: plain weighted sum, MSB plane negated in the signed build
    function automatic res_t model(input pl_t p [inputPrecision]);
        res_t r;
        for (int c = 0; c < NC; c++) begin
            int s = 0;
            for (int k = 0; k < inputPrecision; k++) begin
                int term = int'(p[k][c]) * (1 << k);
`ifdef SIGNED_MSB_EN
                if (k == inputPrecision - 1) s -= term;
                else s += term;
`else
                s += term;
`endif
            end
            r[c] = accWidth'(s);
        end
        return r;
    endfunction

    function automatic res_t pop_exp();
        res_t r;
        if (sb.size() == 0) r = 'x;
        else r = sb.pop_front();
        return r;
    endfunction

    task automatic feed(input pl_t p [inputPrecision], input int gap);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int k = 0; k < inputPrecision; k++) begin
            if (k == inputPrecision - 1) sb.push_back(model(p));
            bus.plane_valid_i = 1'b1;
            bus.plane_i       = p[k];
            tick();
            bus.plane_valid_i = 1'b0;
            if (k < inputPrecision - 1) repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        bus.start_i       = 1'b0;
        bus.plane_valid_i = 1'b0;
        bus.plane_i       = '0;
        bus.acc_ready_i   = 1'b0;
        nrst              = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.acc_valid_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", bus.overrun_o); end
        n_cmp++; if (bus.acc_o !== res_t'(0)) begin n_bad++; $display("FAIL reset_acc: got %h want 0", bus.acc_o); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pl_t  p [inputPrecision];
        res_t exp, lit;
        for (int k = 0; k < inputPrecision; k++) p[k] = mk(3, 3, 3, 3);
        for (int c = 0; c < NC; c++) begin
`ifdef SIGNED_MSB_EN
            lit[c] = 10'h3FD;
`else
            lit[c] = 10'd45;
`endif
        end
        bus.acc_ready_i = 1'b1;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", bus.busy_o); end
        for (int k = 0; k < inputPrecision; k++) begin
            if (k == inputPrecision - 1) sb.push_back(model(p));
            bus.plane_valid_i = 1'b1;
            bus.plane_i       = p[k];
            tick();
            if (k == inputPrecision - 2) begin
                n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", bus.acc_valid_o); end
            end
        end
        bus.plane_valid_i = 1'b0;
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", bus.acc_valid_o); end
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL basic_acc: got %h want %h", bus.acc_o, exp); end
        n_cmp++; if (bus.acc_o !== lit) begin n_bad++; $display("FAIL basic_acc_const: got %h want %h", bus.acc_o, lit); end
        tick();
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop: got %b want 0", bus.acc_valid_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_weighting();
        pl_t  p [inputPrecision];
        res_t exp, lit;
        p[0] = mk(1, 0, 63, 5);
        p[1] = mk(0, 0, 63, 2);
        p[2] = mk(0, 0, 63, 0);
        p[3] = mk(0, 1, 63, 7);
`ifdef SIGNED_MSB_EN
        lit = {10'h3D1, 10'h3C1, 10'h3F8, 10'd1};
`else
        lit = {10'd65, 10'd945, 10'd8, 10'd1};
`endif
        bus.acc_ready_i = 1'b1;
        feed(p, 0);
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_bad++; $display("FAIL weight_valid: got %b want 1", bus.acc_valid_o); end
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL weight_acc: got %h want %h", bus.acc_o, exp); end
        n_cmp++; if (bus.acc_o !== lit) begin n_bad++; $display("FAIL weight_acc_const: got %h want %h", bus.acc_o, lit); end
        tick();
    endtask

    task automatic test_msb_only();
        pl_t  p [inputPrecision];
        res_t exp, lit;
        p[0] = mk(0, 0, 0, 0);
        p[1] = mk(0, 0, 0, 0);
        p[2] = mk(0, 0, 0, 0);
        p[3] = mk(63, 63, 63, 63);
        for (int c = 0; c < NC; c++) begin
`ifdef SIGNED_MSB_EN
            lit[c] = 10'h208;
`else
            lit[c] = 10'd504;
`endif
        end
        bus.acc_ready_i = 1'b1;
        feed(p, 0);
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL msb_acc: got %h want %h", bus.acc_o, exp); end
        n_cmp++; if (bus.acc_o !== lit) begin n_bad++; $display("FAIL msb_acc_const: got %h want %h", bus.acc_o, lit); end
        tick();
    endtask

    task automatic test_backpressure();
        pl_t  p [inputPrecision];
        res_t exp;
        for (int k = 0; k < inputPrecision; k++)
            p[k] = mk($urandom_range(63), $urandom_range(63), $urandom_range(63), $urandom_range(63));
        bus.acc_ready_i = 1'b0;
        feed(p, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid_held[%0d]: got %b want 1", i, bus.acc_valid_o); end
            n_cmp++; if (sb.size() == 0 || bus.acc_o !== sb[0]) begin n_bad++; $display("FAIL bp_acc_stable[%0d]: got %h want %h", i, bus.acc_o, (sb.size() > 0) ? sb[0] : res_t'(0)); end
            if (i == 2) begin
                n_cmp++; if (bus.overrun_o !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %b want 1", bus.overrun_o); end
                n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL bp_stay_hold: busy got %b want 0", bus.busy_o); end
            end
            if (i == 3) begin
                n_cmp++; if (bus.overrun_o !== 1'b0) begin n_bad++; $display("FAIL bp_overrun_pulse: got %b want 0", bus.overrun_o); end
            end
        end
        bus.acc_ready_i = 1'b1;
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL bp_acc: got %h want %h", bus.acc_o, exp); end
        tick();
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_valid_drop: got %b want 0", bus.acc_valid_o); end
        for (int k = 0; k < inputPrecision; k++)
            p[k] = mk($urandom_range(63), $urandom_range(63), $urandom_range(63), $urandom_range(63));
        feed(p, 1);
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL bp_next_acc: got %h want %h", bus.acc_o, exp); end
        tick();
    endtask

    task automatic test_restart();
        pl_t  p [inputPrecision];
        res_t exp, lit;
        int   ov = 0;
        for (int k = 0; k < inputPrecision; k++) p[k] = mk(1, 1, 1, 1);
        for (int c = 0; c < NC; c++) begin
`ifdef SIGNED_MSB_EN
            lit[c] = 10'h3FF;
`else
            lit[c] = 10'd15;
`endif
        end
        bus.acc_ready_i = 1'b1;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.plane_valid_i = 1'b1;
            bus.plane_i       = mk(10, 10, 10, 10);
            tick();
            ov += int'(bus.overrun_o);
        end
        bus.plane_valid_i = 1'b0;
        bus.start_i       = 1'b1;
        tick();
        bus.start_i = 1'b0;
        ov += int'(bus.overrun_o);
        for (int k = 0; k < inputPrecision; k++) begin
            if (k == inputPrecision - 1) sb.push_back(model(p));
            bus.plane_valid_i = 1'b1;
            bus.plane_i       = p[k];
            tick();
            ov += int'(bus.overrun_o);
        end
        bus.plane_valid_i = 1'b0;
        n_cmp++; if (ov !== 1) begin n_bad++; $display("FAIL restart_overrun_count: got %0d want 1", ov); end
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL restart_acc: got %h want %h", bus.acc_o, exp); end
        n_cmp++; if (bus.acc_o !== lit) begin n_bad++; $display("FAIL restart_acc_const: got %h want %h", bus.acc_o, lit); end
        tick();
    endtask

    task automatic test_back_to_back();
        pl_t  a [inputPrecision];
        pl_t  b [inputPrecision];
        res_t exp;
        for (int k = 0; k < inputPrecision; k++) begin
            a[k] = mk(k + 1, 2 * k, 40, 63 - k);
            b[k] = mk(7, k, 33 - k, 12 + k);
        end
        bus.acc_ready_i = 1'b0;
        feed(a, 0);
        bus.acc_ready_i = 1'b1;
        bus.start_i     = 1'b1;
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL b2b_first_acc: got %h want %h", bus.acc_o, exp); end
        tick();
        bus.start_i = 1'b0;
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL b2b_no_bubble: busy got %b want 1", bus.busy_o); end
        n_cmp++; if (bus.overrun_o !== 1'b0) begin n_bad++; $display("FAIL b2b_no_overrun: got %b want 0", bus.overrun_o); end
        bus.plane_valid_i = 1'b1;
        bus.plane_i       = mk(50, 50, 50, 50);
        tick();
        bus.start_i = 1'b1;
        bus.plane_i = b[0];
        tick();
        bus.start_i = 1'b0;
        n_cmp++; if (bus.overrun_o !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_overrun: got %b want 1", bus.overrun_o); end
        for (int k = 1; k < inputPrecision; k++) begin
            if (k == inputPrecision - 1) sb.push_back(model(b));
            bus.plane_i = b[k];
            tick();
        end
        bus.plane_valid_i = 1'b0;
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", bus.acc_valid_o); end
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL b2b_second_acc: got %h want %h", bus.acc_o, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        pl_t  p [inputPrecision];
        res_t exp;
        for (int k = 0; k < inputPrecision; k++) p[k] = mk(9, 17, 2 * k, 60);
        bus.acc_ready_i = 1'b1;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.plane_valid_i = 1'b1;
            bus.plane_i       = mk(30, 30, 30, 30);
            tick();
        end
        bus.plane_valid_i = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", bus.acc_valid_o); end
        n_cmp++; if (bus.acc_o !== res_t'(0)) begin n_bad++; $display("FAIL rstmid_acc: got %h want 0", bus.acc_o); end
        tick();
        nrst = 1'b1;
        tick();
        feed(p, 0);
        exp = pop_exp();
        n_cmp++; if (bus.acc_o !== exp) begin n_bad++; $display("FAIL rstmid_fresh_acc: got %h want %h", bus.acc_o, exp); end
        tick();
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_weighting();
        test_msb_only();
        test_backpressure();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
